// File: rtl/gate_sweep_if.sv
// Handshake and result bundle between a truth-table sweeper and its controller.
// The controller drives start/mode; the sweeper returns stimulus, gate output and results.
interface gate_sweep_if #(
   parameter int N = 3
);
   logic                start;
   logic [2:0]          mode;
   logic [N-1:0]        x;
   logic                z;
   logic                busy;
   logic                done;
   logic [(2**N)-1:0]   truth_table;
   logic [N:0]          ones;

   modport master (
      output start, mode,
      input  x, z, busy, done, truth_table, ones
   );

   modport slave (
      input  start, mode,
      output x, z, busy, done, truth_table, ones
   );
endinterface

// File: rtl/gate_sweep.sv
// Sweeps every input combination of an N-input reduction gate, holding each for
// DWELL cycles, and captures the observed outputs into a truth table.
module gate_sweep #(
   parameter int N     = 3,
   parameter int DWELL = 20
) (
   input  logic         clk,
   input  logic         rst,
   gate_sweep_if.slave  bus
);
   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [N-1:0]    X_LAST     = '1;
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t              state;
   state_t              state_next;
   logic [2:0]          mode_q;
   logic [N-1:0]        x;
   logic [DW_W-1:0]     dwell;
   logic [(2**N)-1:0]   truth_table;
   logic [N:0]          ones;
   logic                z;
   logic                dwell_last;

   function automatic logic gate_eval(input logic [2:0] m, input logic [N-1:0] v);
      case (m)
         3'd0:    return &v;
         3'd1:    return |v;
         3'd2:    return ^v;
         3'd3:    return ~&v;
         3'd4:    return ~|v;
         3'd5:    return ~^v;
         default: return 1'b0;
      endcase
   endfunction

   assign z          = gate_eval(mode_q, x);
   assign dwell_last = (dwell == DWELL_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (bus.start) state_next = S_RUN;
         S_RUN:   if (dwell_last && (x == X_LAST)) state_next = S_FIN;
         S_FIN:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Datapath: x and dwell step together; the sample lands on the last dwell cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q      <= 3'd0;
         x           <= '0;
         dwell       <= '0;
         truth_table <= '0;
         ones        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  mode_q      <= bus.mode;
                  x           <= '0;
                  dwell       <= '0;
                  truth_table <= '0;
                  ones        <= '0;
               end
            end
            S_RUN: begin
               if (dwell_last) begin
                  truth_table[x] <= z;
                  ones           <= ones + {{N{1'b0}}, z};
                  dwell          <= '0;
                  x              <= (x == X_LAST) ? '0 : x + 1'b1;
               end else begin
                  dwell <= dwell + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.x           = x;
   assign bus.z           = z;
   assign bus.busy        = (state == S_RUN);
   assign bus.done        = (state == S_FIN);
   assign bus.truth_table = truth_table;
   assign bus.ones        = ones;
endmodule

// File: tb/tb_gate_sweep.sv
// Directed bench for gate_sweep across three configurations (N=3/DWELL=20,
// N=1/DWELL=1, N=8/DWELL=1) with hand-computed truth tables.
module tb_gate_sweep;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_v = 1'b0;
   logic [2:0] mode_v = 3'd0;
   int         sel = 0;
   int         total = 0;
   int         bad = 0;

   int   cur_x;
   logic cur_busy;
   logic cur_done;

   always #5 clk = ~clk;

   gate_sweep_if #(.N(3)) b3 ();
   gate_sweep_if #(.N(1)) b1 ();
   gate_sweep_if #(.N(8)) b8 ();

   assign b3.start = start_v && (sel == 0);
   assign b1.start = start_v && (sel == 1);
   assign b8.start = start_v && (sel == 2);
   assign b3.mode  = mode_v;
   assign b1.mode  = mode_v;
   assign b8.mode  = mode_v;

   gate_sweep #(.N(3), .DWELL(20)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));
   gate_sweep #(.N(1), .DWELL(1))  u1 (.clk(clk), .rst(rst), .bus(b1.slave));
   gate_sweep #(.N(8), .DWELL(1))  u8 (.clk(clk), .rst(rst), .bus(b8.slave));

   always_comb begin
      cur_x    = 0;
      cur_busy = 1'b0;
      cur_done = 1'b0;
      case (sel)
         0: begin cur_x = int'(b3.x); cur_busy = b3.busy; cur_done = b3.done; end
         1: begin cur_x = int'(b1.x); cur_busy = b1.busy; cur_done = b1.done; end
         default: begin cur_x = int'(b8.x); cur_busy = b8.busy; cur_done = b8.done; end
      endcase
   end

   // Holds start until the selected instance goes busy, then counts cycles
   // (cycle 1 = first cycle after the accepting edge) up to the done pulse.
   task automatic sweep(input int s, input logic [2:0] m, input int probe_cyc,
                        input int glitch_cyc, output int waits, output int done_cyc,
                        output int busy_cnt, output int probe_x);
      sel = s;
      mode_v = m;
      @(negedge clk);
      start_v = 1'b1;
      waits = 0;
      do begin
         @(posedge clk);
         #1;
         waits++;
      end while (!cur_busy && waits < 10);
      start_v  = 1'b0;
      done_cyc = -1;
      busy_cnt = 0;
      probe_x  = -1;
      for (int c = 1; c < 2000; c++) begin
         if (cur_busy) busy_cnt++;
         if (c == probe_cyc) probe_x = cur_x;
         if (cur_done) begin
            done_cyc = c;
            break;
         end
         if (c == glitch_cyc) begin
            start_v = 1'b1;
            mode_v  = 3'd0;
         end else begin
            start_v = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      start_v = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (b3.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", b3.busy); end
      total++; if (b3.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", b3.done); end
      total++; if (b3.x !== 3'd0) begin bad++; $display("FAIL reset_x got=%0d want=0", b3.x); end
      total++; if (b3.z !== 1'b0) begin bad++; $display("FAIL reset_z got=%b want=0", b3.z); end
      total++; if (b3.truth_table !== 8'h00) begin bad++; $display("FAIL reset_table got=%h want=00", b3.truth_table); end
      total++; if (b3.ones !== 4'd0) begin bad++; $display("FAIL reset_ones got=%0d want=0", b3.ones); end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (b3.busy !== 1'b0) begin bad++; $display("FAIL idle_no_start busy got=%b want=0", b3.busy); end
   endtask

   task automatic test_or_sweep();
      int w, d, bc, px;
      sweep(0, 3'd1, 61, -1, w, d, bc, px);
      total++; if (w !== 1) begin bad++; $display("FAIL or_accept_edges got=%0d want=1", w); end
      total++; if (d !== 161) begin bad++; $display("FAIL or_done_cycle got=%0d want=161", d); end
      total++; if (bc !== 160) begin bad++; $display("FAIL or_busy_cycles got=%0d want=160", bc); end
      total++; if (px !== 3) begin bad++; $display("FAIL or_x_at_61 got=%0d want=3", px); end
      total++; if (b3.truth_table !== 8'hFE) begin bad++; $display("FAIL or_table got=%h want=fe", b3.truth_table); end
      total++; if (b3.ones !== 4'd7) begin bad++; $display("FAIL or_ones got=%0d want=7", b3.ones); end
      total++; if (b3.x !== 3'd0) begin bad++; $display("FAIL or_x_final got=%0d want=0", b3.x); end
      total++; if (b3.busy !== 1'b0) begin bad++; $display("FAIL or_busy_at_done got=%b want=0", b3.busy); end
   endtask

   task automatic test_back_to_back();
      logic [2:0] modes [5]  = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5};
      logic [7:0] tables [5] = '{8'h80, 8'h96, 8'h7F, 8'h01, 8'h69};
      int         onesx [5]  = '{1, 4, 7, 1, 4};
      int w, d, bc, px;
      for (int i = 0; i < 5; i++) begin
         sweep(0, modes[i], -1, -1, w, d, bc, px);
         total++; if (w !== 2) begin bad++; $display("FAIL b2b_accept_edges mode=%0d got=%0d want=2", modes[i], w); end
         total++; if (d !== 161) begin bad++; $display("FAIL b2b_done mode=%0d got=%0d want=161", modes[i], d); end
         total++; if (b3.truth_table !== tables[i]) begin bad++; $display("FAIL b2b_table mode=%0d got=%h want=%h", modes[i], b3.truth_table, tables[i]); end
         total++; if (int'(b3.ones) !== onesx[i]) begin bad++; $display("FAIL b2b_ones mode=%0d got=%0d want=%0d", modes[i], b3.ones, onesx[i]); end
      end
      @(posedge clk);
      #1;
      total++; if (b3.done !== 1'b0) begin bad++; $display("FAIL done_single_cycle got=%b want=0", b3.done); end
   endtask

   task automatic test_ignore_inputs();
      int w, d, bc, px;
      sweep(0, 3'd2, -1, 40, w, d, bc, px);
      total++; if (d !== 161) begin bad++; $display("FAIL ignore_done_cycle got=%0d want=161", d); end
      total++; if (b3.truth_table !== 8'h96) begin bad++; $display("FAIL ignore_table got=%h want=96", b3.truth_table); end
      total++; if (b3.ones !== 4'd4) begin bad++; $display("FAIL ignore_ones got=%0d want=4", b3.ones); end
      @(posedge clk);
      #1;
      total++; if (b3.busy !== 1'b0 || b3.done !== 1'b0) begin bad++; $display("FAIL ignore_no_requeue busy=%b done=%b want=0/0", b3.busy, b3.done); end
   endtask

   task automatic test_reset_mid();
      int w, d, bc, px, dones;
      sel = 0;
      mode_v = 3'd1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      start_v = 1'b1;
      @(posedge clk);
      #1;
      start_v = 1'b0;
      repeat (49) @(posedge clk);
      #1;
      total++; if (b3.truth_table !== 8'h02 || b3.ones !== 4'd1) begin bad++; $display("FAIL mid_partial table=%h ones=%0d want=02/1", b3.truth_table, b3.ones); end
      total++; if (b3.x !== 3'd2 || b3.busy !== 1'b1) begin bad++; $display("FAIL mid_state x=%0d busy=%b want=2/1", b3.x, b3.busy); end
      #2;
      rst = 1'b1;
      #1;
      total++; if (b3.busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%b want=0", b3.busy); end
      total++; if (b3.x !== 3'd0) begin bad++; $display("FAIL async_x got=%0d want=0", b3.x); end
      total++; if (b3.truth_table !== 8'h00 || b3.ones !== 4'd0) begin bad++; $display("FAIL async_results table=%h ones=%0d want=00/0", b3.truth_table, b3.ones); end
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         #1;
         if (b3.done) dones++;
      end
      total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
      sweep(0, 3'd1, -1, -1, w, d, bc, px);
      total++; if (d !== 161 || b3.truth_table !== 8'hFE) begin bad++; $display("FAIL after_reset_sweep done=%0d table=%h want=161/fe", d, b3.truth_table); end
   endtask

   task automatic test_n1_nand();
      int w, d, bc, px;
      sweep(1, 3'd3, 2, -1, w, d, bc, px);
      total++; if (d !== 3) begin bad++; $display("FAIL n1_done_cycle got=%0d want=3", d); end
      total++; if (px !== 1) begin bad++; $display("FAIL n1_x_at_2 got=%0d want=1", px); end
      total++; if (b1.truth_table !== 2'b01) begin bad++; $display("FAIL n1_table got=%b want=01", b1.truth_table); end
      total++; if (b1.ones !== 2'd1) begin bad++; $display("FAIL n1_ones got=%0d want=1", b1.ones); end
   endtask

   task automatic test_n8_xor();
      int w, d, bc, px;
      logic [255:0] exp_tbl;
      for (int k = 0; k < 256; k++) begin
         exp_tbl[k] = ^(8'(k));
      end
      sweep(2, 3'd2, -1, -1, w, d, bc, px);
      total++; if (d !== 257) begin bad++; $display("FAIL n8_done_cycle got=%0d want=257", d); end
      total++; if (b8.ones !== 9'd128) begin bad++; $display("FAIL n8_ones got=%0d want=128", b8.ones); end
      total++; if (b8.truth_table !== exp_tbl) begin bad++; $display("FAIL n8_table low64 got=%h want=%h", b8.truth_table[63:0], exp_tbl[63:0]); end
   endtask

   initial begin
      test_reset();
      test_or_sweep();
      test_back_to_back();
      test_ignore_inputs();
      test_reset_mid();
      test_n1_nand();
      test_n8_xor();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
